apb3_timer_slave: RTL and testbench

- APB3 completer (slave) peripheral that sits on one PSELSx slot of the APB3 interconnect.
- It is a 32-bit down-counting timer with prescaler, periodic and one-shot modes, and a level interrupt.
- Supports a configurable number of wait states (PREADY low) and flags PSLVERR on illegal accesses.
- It is the responder-side counterpart to the APB3 fabric and gives the fabric a real slave to select.

---
 rtl/apb3_timer_slave.sv | 123 ++++++++++++
 tb/tb_apb3_timer_slave.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_timer_slave.sv
// rtl/apb3_timer_slave.sv - APB3 completer wrapping a 32-bit prescaled down-counting timer
// Periodic or one-shot countdown with level interrupt, optional wait states and PSLVERR decode.
module apb3_timer_slave #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int PRESC_W     = 8
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              TIMINT
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0]        load_q, load_d;
  logic [31:0]        value_q, value_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic               ris_q, ris_d;
  logic [3:0]         wcnt_q, wcnt_d;

  logic        access, done, err, wr_ok;
  logic        wr_load, wr_ctrl, wr_presc, wr_intclr;
  logic        tick, expire;
  logic [2:0]  idx;
  logic [31:0] rdata;
  logic        unused_addr;

  assign unused_addr = ^PADDR[1:0];
  assign idx         = PADDR[4:2];
  assign access      = PSEL & PENABLE;
  assign PREADY      = access ? (wcnt_q == WS) : 1'b1;
  assign done        = access & PREADY;

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    case (idx)
      3'd0:    rdata = load_q;
      3'd1:    begin rdata = value_q; err = PWRITE; end
      3'd2:    rdata = {29'd0, ctrl_q};
      3'd3:    rdata = 32'(presc_q);
      3'd4:    begin rdata = {31'd0, ris_q}; err = PWRITE; end
      3'd5:    rdata = '0;
      default: err = 1'b1;
    endcase
    if (PADDR[ADDR_W-1:5] != '0) begin
      err   = 1'b1;
      rdata = '0;
    end
  end

  assign PRDATA  = (done && !err) ? rdata : '0;
  assign PSLVERR = done & err;
  assign TIMINT  = ris_q & ctrl_q[1];

  assign wr_ok     = done & PWRITE & ~err;
  assign wr_load   = wr_ok & (idx == 3'd0);
  assign wr_ctrl   = wr_ok & (idx == 3'd2);
  assign wr_presc  = wr_ok & (idx == 3'd3);
  assign wr_intclr = wr_ok & (idx == 3'd5);

  assign tick   = ctrl_q[0] & (pcnt_q == presc_q);
  // A LOAD write on the same edge discards the tick, including its interrupt and one-shot stop.
  assign expire = tick & (value_q == 32'd1) & ~wr_load;

  always_comb begin
    wcnt_d  = (access && !PREADY) ? wcnt_q + 4'd1 : 4'd0;
    pcnt_d  = (!ctrl_q[0] || tick || wr_load || wr_presc) ? '0 : pcnt_q + 1'b1;
    load_d  = load_q;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    ris_d   = ris_q;

    if (tick) begin
      if (value_q > 32'd1)  value_d = value_q - 32'd1;
      else if (!ctrl_q[2])  value_d = load_q;
      else                  value_d = '0;
    end
    if (expire && ctrl_q[2]) ctrl_d[0] = 1'b0;

    if (wr_intclr) ris_d = 1'b0;
    if (expire)    ris_d = 1'b1;

    if (wr_load) begin
      load_d  = PWDATA;
      value_d = PWDATA;
    end
    if (wr_ctrl)  ctrl_d  = PWDATA[2:0];
    if (wr_presc) presc_d = PWDATA[PRESC_W-1:0];
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      load_q  <= '0;
      value_q <= '0;
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      ris_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      load_q  <= load_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      ris_q   <= ris_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_apb3_timer_slave.sv
// tb/tb_apb3_timer_slave.sv - self-checking bench for apb3_timer_slave
// Zero-wait-state instance tracked by a transfer-level model; a three-wait-state instance checked directly.
module tb_apb3_timer_slave;

  logic        clk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, timint;
  logic        psel3, penable3;
  logic [31:0] prdata3;
  logic        pready3, pslverr3, timint3;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  apb3_timer_slave #(.ADDR_W(8), .WAIT_STATES(0), .PRESC_W(8)) u_dut (
    .PCLK(clk), .PRESETN(presetn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr), .TIMINT(timint)
  );

  apb3_timer_slave #(.ADDR_W(8), .WAIT_STATES(3), .PRESC_W(8)) u_dut_ws3 (
    .PCLK(clk), .PRESETN(presetn), .PSEL(psel3), .PENABLE(penable3), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3),
    .PSLVERR(pslverr3), .TIMINT(timint3)
  );

  typedef struct packed {
    logic [31:0] load;
    logic [31:0] value;
    logic [2:0]  ctrl;
    logic [7:0]  presc;
    logic [7:0]  pcnt;
    logic        ris;
  } mstate_t;

  mstate_t m;

  function automatic bit m_legal(logic [7:0] a, bit wr);
    logic [2:0] i;
    i = a[4:2];
    return (a[7:5] == 3'd0) && (i < 3'd6) && !(wr && (i == 3'd1 || i == 3'd4));
  endfunction

  function automatic logic [32:0] m_read(mstate_t s, logic [7:0] a, bit wr);
    if (!m_legal(a, wr)) return {1'b1, 32'd0};
    case (a[4:2])
      3'd0:    return {1'b0, s.load};
      3'd1:    return {1'b0, s.value};
      3'd2:    return {1'b0, 29'd0, s.ctrl};
      3'd3:    return {1'b0, 24'd0, s.presc};
      3'd4:    return {1'b0, 31'd0, s.ris};
      default: return 33'd0;
    endcase
  endfunction

  // One clock edge of the timer as described in prose: prescaler tick, countdown rules, then a completed write.
  function automatic mstate_t m_step(mstate_t s, bit xfer, bit wr, logic [7:0] a, logic [31:0] wd);
    mstate_t t;
    bit en, fires, hits_one;
    t        = s;
    en       = s.ctrl[0];
    fires    = en && (s.pcnt == s.presc);
    hits_one = fires && (s.value == 32'd1);
    t.pcnt   = (en && !fires) ? s.pcnt + 8'd1 : 8'd0;
    if (fires) begin
      if (s.value > 32'd1) t.value = s.value - 32'd1;
      else if (s.value == 32'd1) begin
        t.ris = 1'b1;
        if (s.ctrl[2]) begin t.value = 32'd0; t.ctrl[0] = 1'b0; end
        else t.value = s.load;
      end else if (!s.ctrl[2]) t.value = s.load;
    end
    if (xfer && wr && m_legal(a, wr)) begin
      case (a[4:2])
        3'd0: begin t.load = wd; t.value = wd; t.pcnt = 8'd0; t.ris = s.ris; t.ctrl = s.ctrl; end
        3'd2: t.ctrl = wd[2:0];
        3'd3: begin t.presc = wd[7:0]; t.pcnt = 8'd0; end
        3'd5: t.ris = hits_one;
        default: ;
      endcase
    end
    return t;
  endfunction

  always @(posedge clk or negedge presetn) begin
    if (!presetn) m <= '0;
    else          m <= m_step(m, psel && penable, pwrite, paddr, pwdata);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic apb0(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er);
    logic [32:0] exp;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    #1;
    check_eq("setup_pready", pready, 1);
    check_eq("setup_pslverr", pslverr, 0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    exp = m_read(m, a, wr);
    check_eq("access_pready", pready, 1);
    check_eq("pslverr", pslverr, exp[32]);
    if (!wr) check_eq("prdata", prdata, exp[31:0]);
    check_eq("timint", timint, m.ris & m.ctrl[1]);
    rd = prdata;
    er = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb3(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int waits);
    waits = 0;
    @(negedge clk);
    psel3 = 1'b1; penable3 = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable3 = 1'b1;
    #1;
    while (!pready3 && waits < 20) begin
      check_eq("ws3_prdata_wait", prdata3, 0);
      waits++;
      @(negedge clk);
      #1;
    end
    check_eq("ws3_ready_seen", pready3, 1);
    rd = prdata3;
    er = pslverr3;
    @(negedge clk);
    psel3 = 1'b0; penable3 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      check_eq("idle_timint", timint, m.ris & m.ctrl[1]);
    end
  endtask

  task automatic wait_int(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timint && k < 60);
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic [7:0]  a;
    bit          er, wr;
    int          k, w, c1, c2;

    presetn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    psel3 = 1'b0; penable3 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_pready", pready, 1);
    check_eq("rst_pslverr", pslverr, 0);
    check_eq("rst_prdata", prdata, 0);
    check_eq("rst_timint", timint, 0);
    presetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      apb0(1'b0, 8'(i * 4), 32'd0, rd, er);
      check_eq("rst_read_val", rd, 0);
      check_eq("rst_read_err", 32'(er), 0);
    end

    // Periodic: LOAD=5, PRESCALE=1 gives an interrupt every 10 cycles.
    apb0(1'b1, 8'h00, 32'd5, rd, er);
    apb0(1'b1, 8'h0C, 32'd1, rd, er);
    apb0(1'b1, 8'h08, 32'h3, rd, er);
    wait_int(k);
    check_eq("periodic_first_int", k, 10);
    c1 = cyc;
    apb0(1'b0, 8'h04, 32'd0, rd, er);
    check_eq("periodic_reload", rd, 4);
    apb0(1'b1, 8'h14, 32'd0, rd, er);
    wait_int(k);
    c2 = cyc;
    check_eq("periodic_period", c2 - c1, 10);

    // One-shot: three ticks to expiry, then EN self-clears.
    apb0(1'b1, 8'h08, 32'h0, rd, er);
    apb0(1'b1, 8'h14, 32'd0, rd, er);
    apb0(1'b1, 8'h00, 32'd3, rd, er);
    apb0(1'b1, 8'h0C, 32'd0, rd, er);
    apb0(1'b1, 8'h08, 32'h7, rd, er);
    wait_int(k);
    check_eq("oneshot_int", k, 3);
    apb0(1'b0, 8'h04, 32'd0, rd, er);
    check_eq("oneshot_value", rd, 0);
    apb0(1'b0, 8'h08, 32'd0, rd, er);
    check_eq("oneshot_ctrl", rd, 32'h6);
    check_eq("oneshot_int_held", timint, 1);
    apb0(1'b1, 8'h14, 32'd0, rd, er);
    check_eq("oneshot_intclr", timint, 0);

    // Illegal accesses leave state untouched.
    apb0(1'b1, 8'h08, 32'h0, rd, er);
    apb0(1'b1, 8'h00, 32'd7, rd, er);
    apb0(1'b1, 8'h04, 32'h55, rd, er);
    check_eq("err_wr_value", 32'(er), 1);
    apb0(1'b1, 8'h10, 32'h1, rd, er);
    check_eq("err_wr_ris", 32'(er), 1);
    apb0(1'b0, 8'h18, 32'd0, rd, er);
    check_eq("err_rd_18", 32'(er), 1);
    check_eq("err_rd_18_data", rd, 0);
    apb0(1'b1, 8'h40, 32'h99, rd, er);
    check_eq("err_wr_40", 32'(er), 1);
    apb0(1'b0, 8'h40, 32'd0, rd, er);
    check_eq("err_rd_40", 32'(er), 1);
    apb0(1'b0, 8'h00, 32'd0, rd, er);
    check_eq("err_load_kept", rd, 7);
    apb0(1'b0, 8'h04, 32'd0, rd, er);
    check_eq("err_value_kept", rd, 7);
    apb0(1'b0, 8'h10, 32'd0, rd, er);
    check_eq("err_ris_kept", rd, 0);

    // LOAD write on a tick edge: counting resumes from the new LOAD (two ticks before the read samples).
    apb0(1'b1, 8'h00, 32'd100, rd, er);
    apb0(1'b1, 8'h08, 32'h1, rd, er);
    idle(2);
    apb0(1'b1, 8'h00, 32'd9, rd, er);
    apb0(1'b0, 8'h04, 32'd0, rd, er);
    check_eq("load_beats_tick", rd, 7);

    // INTCLR on the edge where RIS sets: RIS stays set.
    apb0(1'b1, 8'h08, 32'h0, rd, er);
    apb0(1'b1, 8'h14, 32'd0, rd, er);
    apb0(1'b1, 8'h00, 32'd3, rd, er);
    apb0(1'b1, 8'h08, 32'h3, rd, er);
    apb0(1'b1, 8'h14, 32'd0, rd, er);
    apb0(1'b0, 8'h10, 32'd0, rd, er);
    check_eq("set_beats_clr", rd, 1);

    // Three wait states on the second instance.
    apb3(1'b1, 8'h00, 32'hA5A5_0001, rd, er, w);
    check_eq("ws3_write_waits", w, 3);
    check_eq("ws3_write_err", 32'(er), 0);
    apb3(1'b0, 8'h00, 32'd0, rd, er, w);
    check_eq("ws3_read_waits", w, 3);
    check_eq("ws3_read_data", rd, 32'hA5A5_0001);
    check_eq("ws3_total_cycles", w + 2, 5);

    // Reset pulsed mid-wait.
    @(negedge clk);
    psel3 = 1'b1; penable3 = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(negedge clk);
    penable3 = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midwait_pready_low", pready3, 0);
    presetn = 1'b0;
    psel3 = 1'b0; penable3 = 1'b0;
    #1;
    check_eq("midwait_rst_pready", pready3, 1);
    check_eq("midwait_rst_timint", timint, 0);
    repeat (2) @(negedge clk);
    presetn = 1'b1;
    apb3(1'b0, 8'h00, 32'd0, rd, er, w);
    check_eq("post_rst_ws3_load", rd, 0);
    for (int i = 0; i < 5; i++) begin
      apb0(1'b0, 8'(i * 4), 32'd0, rd, er);
      check_eq("post_rst_read", rd, 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      a = {3'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a[7:5] = 3'($urandom_range(1, 7));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      case (a[4:2])
        3'd0: if ($urandom_range(0, 7) != 0) wd = $urandom_range(0, 8);
        3'd3: wd[7:0] = 8'($urandom_range(0, 3));
        default: ;
      endcase
      apb0(wr, a, wd, rd, er);
      idle($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
